// File: rtl/rx.sv
// 8N1 serial receiver for the mini-spart UART datapath: 16x oversampled start
// detect, LSB-first shift-in, stop check, with ready/framing/overrun flags.
module rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       en,
    input  logic       clr_rda,
    output logic [7:0] data,
    output logic       rda,
    output logic       ferr,
    output logic       ovr
);

    // state | meaning
    // IDLE  | waiting for rx_s low; en ignored
    // START | counting to mid start bit to confirm or reject it
    // DATA  | sampling 8 data bits at mid-bit, LSB first
    // STOP  | sampling stop bit, loading the frame into the outputs
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [3:0]  tcnt;
    logic [2:0]  bcnt;
    logic [7:0]  shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            tcnt    <= 4'd0;
            bcnt    <= 3'd0;
            shreg   <= 8'h00;
            data    <= 8'h00;
            rda     <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;

            // A load in STOP below overrides this clear when both land together.
            if (clr_rda) begin
                rda <= 1'b0;
                ovr <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        tcnt  <= 4'd0;
                        state <= START;
                    end
                end
                START: begin
                    if (en) begin
                        if (tcnt == 4'd7) begin
                            if (!rx_s) begin
                                tcnt  <= 4'd0;
                                bcnt  <= 3'd0;
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (en) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            shreg <= {rx_s, shreg[7:1]};
                            bcnt  <= bcnt + 3'd1;
                            if (bcnt == 3'd7) begin
                                tcnt  <= 4'd0;
                                state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (en) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == 4'd15) begin
                            data  <= shreg;
                            rda   <= 1'b1;
                            ferr  <= ~rx_s;
                            ovr   <= rda & ~clr_rda;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx: frames driven at 16 en ticks per bit, en every 4 clocks,
// outputs checked against hand-computed values just after the load edge.
module tb_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic       en = 1'b0;
    logic       clr_rda = 1'b0;
    logic [7:0] data;
    logic       rda;
    logic       ferr;
    logic       ovr;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] ecnt = 2'd0;
    logic       pre_rda;
    logic [7:0] pre_data;

    rx dut (
        .clk     (clk),
        .rst     (rst),
        .RxD     (RxD),
        .en      (en),
        .clr_rda (clr_rda),
        .data    (data),
        .rda     (rda),
        .ferr    (ferr),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            ecnt = ecnt + 2'd1;
            en   = (ecnt == 2'd0);
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // returns #1 after the n-th following clock edge that carries en
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            @(posedge clk);
            while (en !== 1'b1) begin
                guard++;
                if (guard > 8) begin
                    n_err++;
                    $display("FAIL en_timeout: got no en within %0d clocks expected one", guard);
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                    $fatal(1, "en generator stalled");
                end
                @(posedge clk);
            end
            #1;
        end
    endtask

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts just after an en edge; returns just after the tick-152 load edge
    // with the line back high. clr_at_load drives clr_rda only in the load cycle.
    task automatic send_to_load(input logic [7:0] b, input logic stop, input logic clr_at_load);
        RxD = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            wait_ticks(16);
        end
        RxD = stop;
        wait_ticks(7);
        clocks(3);
        pre_rda  = rda;
        pre_data = data;
        clr_rda  = clr_at_load;
        clocks(1);
        clr_rda  = 1'b0;
        RxD      = 1'b1;
    endtask

    task automatic finish_stop();
        wait_ticks(8);
    endtask

    task automatic pulse_clr();
        clr_rda = 1'b1;
        clocks(1);
        clr_rda = 1'b0;
    endtask

    initial begin
        // reset state
        RxD = 1'b1;
        rst = 1'b1;
        clocks(3);
        rst = 1'b0;
        chk("rst_data", data, 8'h00);
        chk("rst_rda", {7'd0, rda}, 8'h01 & 8'h00);
        chk("rst_ferr", {7'd0, ferr}, 8'h00);
        chk("rst_ovr", {7'd0, ovr}, 8'h00);
        wait_ticks(4);

        // nominal frame, load lands exactly on tick 152
        send_to_load(8'hA5, 1'b1, 1'b0);
        chk("a5_pre_rda", {7'd0, pre_rda}, 8'h00);
        chk("a5_pre_data", pre_data, 8'h00);
        chk("a5_data", data, 8'hA5);
        chk("a5_rda", {7'd0, rda}, 8'h01);
        chk("a5_ferr", {7'd0, ferr}, 8'h00);
        chk("a5_ovr", {7'd0, ovr}, 8'h00);
        pulse_clr();
        chk("a5_clr_rda", {7'd0, rda}, 8'h00);
        chk("a5_clr_data", data, 8'hA5);
        finish_stop();

        // back-to-back frames, no idle gap
        send_to_load(8'h00, 1'b1, 1'b0);
        chk("b2b0_data", data, 8'h00);
        chk("b2b0_rda", {7'd0, rda}, 8'h01);
        chk("b2b0_ferr", {7'd0, ferr}, 8'h00);
        chk("b2b0_ovr", {7'd0, ovr}, 8'h00);
        pulse_clr();
        finish_stop();
        send_to_load(8'hFF, 1'b1, 1'b0);
        chk("b2b1_data", data, 8'hFF);
        chk("b2b1_ferr", {7'd0, ferr}, 8'h00);
        chk("b2b1_ovr", {7'd0, ovr}, 8'h00);
        pulse_clr();
        finish_stop();

        // framing error, then a clean frame clears ferr
        send_to_load(8'h3C, 1'b0, 1'b0);
        chk("fe_data", data, 8'h3C);
        chk("fe_rda", {7'd0, rda}, 8'h01);
        chk("fe_ferr", {7'd0, ferr}, 8'h01);
        pulse_clr();
        chk("fe_clr_ferr_held", {7'd0, ferr}, 8'h01);
        finish_stop();
        send_to_load(8'h55, 1'b1, 1'b0);
        chk("fe55_data", data, 8'h55);
        chk("fe55_ferr", {7'd0, ferr}, 8'h00);
        chk("fe55_rda", {7'd0, rda}, 8'h01);
        pulse_clr();
        finish_stop();

        // overrun
        send_to_load(8'h12, 1'b1, 1'b0);
        chk("ov12_data", data, 8'h12);
        chk("ov12_ovr", {7'd0, ovr}, 8'h00);
        finish_stop();
        send_to_load(8'h34, 1'b1, 1'b0);
        chk("ov34_data", data, 8'h34);
        chk("ov34_rda", {7'd0, rda}, 8'h01);
        chk("ov34_ovr", {7'd0, ovr}, 8'h01);
        pulse_clr();
        chk("ov_clr_rda", {7'd0, rda}, 8'h00);
        chk("ov_clr_ovr", {7'd0, ovr}, 8'h00);
        finish_stop();

        // clr_rda coincident with the load: load wins, no overrun
        send_to_load(8'h12, 1'b1, 1'b0);
        finish_stop();
        send_to_load(8'h34, 1'b1, 1'b1);
        chk("co_pre_rda", {7'd0, pre_rda}, 8'h01);
        chk("co_data", data, 8'h34);
        chk("co_rda", {7'd0, rda}, 8'h01);
        chk("co_ovr", {7'd0, ovr}, 8'h00);
        pulse_clr();
        finish_stop();

        // glitch rejection
        RxD = 1'b0;
        wait_ticks(4);
        RxD = 1'b1;
        wait_ticks(12);
        chk("gl_rda", {7'd0, rda}, 8'h00);
        chk("gl_data", data, 8'h34);
        chk("gl_ferr", {7'd0, ferr}, 8'h00);
        chk("gl_ovr", {7'd0, ovr}, 8'h00);
        send_to_load(8'h81, 1'b1, 1'b0);
        chk("gl81_data", data, 8'h81);
        chk("gl81_rda", {7'd0, rda}, 8'h01);
        finish_stop();

        // reset mid-DATA, with rda set beforehand
        RxD = 1'b0;
        wait_ticks(16);
        RxD = 1'b1;
        wait_ticks(24);
        rst = 1'b1;
        clocks(2);
        rst = 1'b0;
        chk("mr_rda", {7'd0, rda}, 8'h00);
        chk("mr_data", data, 8'h00);
        wait_ticks(20);
        chk("mr_idle_rda", {7'd0, rda}, 8'h00);
        send_to_load(8'hC3, 1'b1, 1'b0);
        chk("mrC3_data", data, 8'hC3);
        chk("mrC3_rda", {7'd0, rda}, 8'h01);
        chk("mrC3_ferr", {7'd0, ferr}, 8'h00);
        finish_stop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx.md
# rx

Serial receiver for the mini-spart UART datapath; the receive-side counterpart of the transmitter. It oversamples the `RxD` line using the shared 16x baud enable and detects a start bit, then shifts in 8 data bits LSB-first and checks the stop bit. The received byte is presented on `data` with a ready flag (`rda`) that stays set until the bus interface acknowledges it. Framing and overrun errors are flagged alongside the byte.

## Interface
- No parameters; frame format fixed at 8N1, oversample ratio fixed at 16.
- `clk`  in  1  system clock; one clock; all state updates on rising edge
- `rst`  in  1  reset is synchronous and active-high
- `RxD`  in  1  asynchronous serial line, idle high
- `en`  in  1  16x baud tick, one `clk` cycle wide
- `clr_rda`  in  1  one-cycle pulse: byte consumed; clears `rda` and `ovr`
- `data`  out  8  last received byte; reset 8'h00
- `rda`  out  1  received data available; reset 0
- `ferr`  out  1  stop bit of the byte in `data` sampled low; reset 0
- `ovr`  out  1  byte loaded while `rda` still set; reset 0

## Operation
- Synchronizer: `RxD` passes through 2 flops (reset value 1) to give `rx_s`. All decisions use `rx_s` only.
- Counters: 4-bit tick counter `tcnt` advances only on `en` cycles. 3-bit bit index `bcnt`. 8-bit shift register `shreg`, which shifts right with the new bit entering at bit 7 (LSB-first line order).
- States: IDLE, START, DATA, STOP.
  - IDLE: `en` is ignored. If `rx_s`==0 on any clock: `tcnt`<=0, go to START.
  - START: on each `en`, `tcnt`++. On the 8th `en` (`tcnt`==7 at that `en`), sample `rx_s` (mid start bit):
    - 0: `tcnt`<=0, `bcnt`<=0, go to DATA.
    - 1: false start (glitch). Go to IDLE; no flags change.
  - DATA: on each `en`, `tcnt`++ (wraps 15->0). On the 16th `en` (`tcnt`==15), shift `rx_s` into `shreg` and increment `bcnt`. After the shift with `bcnt`==7, `tcnt`<=0 and go to STOP.
  - STOP: on the 16th `en`, load the frame:
    - `data`<=`shreg`, `rda`<=1, `ferr`<=~`rx_s`.
    - `ovr`<=1 if `rda`==1 and `clr_rda`==0 in that cycle; otherwise `ovr`<=0.
    - Go to IDLE in the same edge, so a back-to-back start bit can be detected from the next clock.
- On a framing error the byte is still loaded and `rda` still set; `ferr` qualifies it.
- `clr_rda` with no load in the same cycle: `rda`<=0, `ovr`<=0; `data` and `ferr` are held.
- `clr_rda` coincident with a load: the load wins (`rda`=1, new `data`), and `ovr`=0.
- `clr_rda` while `rda`==0 has no effect.
- `rst` asserted at any time, including mid-frame: next edge forces IDLE, counters 0, synchronizer 1, and all outputs to their reset values. A line held low through reset is seen as a start once `rx_s` falls after reset.

## Timing
- Detection: line falling edge to START entry takes 3 clocks (2 sync flops plus 1 state register).
- Sample points, counted in `en` ticks after START entry:
  - start check at tick 8
  - data bit k (k=0..7) at tick 8+16(k+1)
  - stop bit at tick 152
- `rda`, `data`, `ferr` and `ovr` update on the clock edge of the tick-152 `en` and are visible the following cycle.
- An `en` arriving in the same cycle as the START transition is not counted.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive `RxD`=1 and pulse `rst` -> `data`=00, `rda`=0, `ferr`=0, `ovr`=0, state IDLE. Assert `rst` mid-DATA -> `rda` stays 0 and the next clean frame is received correctly.
- Nominal frame, `en` every 4 clocks: send 0xA5 at 16 `en`/bit, stop=1 -> `data`=A5, `rda`=1, `ferr`=0 exactly at tick 152. Pulse `clr_rda` -> `rda`=0 next cycle, `data` held at A5.
- Back-to-back: send 0x00 then 0xFF with no idle gap, reading each byte -> `data`=00 then FF, `ferr`=0, `ovr`=0.
- Framing error: send 0x3C with stop bit = 0 -> `data`=3C, `rda`=1, `ferr`=1. The next good frame 0x55 (after `clr_rda`) -> `ferr`=0.
- Overrun and boundary: send 0x12 and 0x34 without `clr_rda` -> `data`=34, `ovr`=1. Repeat with `clr_rda` pulsed exactly on the 0x34 load cycle -> `rda`=1, `ovr`=0.
- Glitch rejection: pull `RxD` low for 4 `en` ticks, then high -> return to IDLE with no flag change. A following valid 0x81 frame -> `data`=81.
